// File: rtl/alu_seq.sv
// Registered multi-cycle ALU: single-cycle logic/arith/shift ops, shift-add unsigned multiply,
// internal PSR flag register feeding ADDC/SUBC carry-in, start/ready/done handshake.
module alu_seq #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [7:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic [4:0]       flags,
   output logic             ready,
   output logic             done,
   output logic             err
);

   typedef enum logic [1:0] {S_IDLE, S_MULT, S_DONE} state_t;

   typedef enum logic [4:0] {
      OP_WAIT, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADD, OP_ADDU, OP_ADDC, OP_SUB,
      OP_SUBC, OP_CMP, OP_CMPU, OP_MUL, OP_LSH, OP_RSH, OP_ALSH, OP_ARSH, OP_UNDEF
   } op_t;

   localparam logic [SHW:0]   SH_MAX   = (SHW+1)'(WIDTH);
   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH-1);

   // Register form is 0x0N; immediate form repeats N in the high nibble. 0x8N are shifts.
   function automatic op_t decode(input logic [7:0] opc);
      op_t        op;
      logic [3:0] sel;
      op = OP_UNDEF;
      if (opc[7:4] == 4'h8) begin
         case (opc[3:0])
            4'h0, 4'h4: op = OP_LSH;
            4'h1, 4'h5: op = OP_RSH;
            4'h2, 4'h6: op = OP_ALSH;
            4'h3, 4'h7: op = OP_ARSH;
            default:    op = OP_UNDEF;
         endcase
      end else begin
         sel = (opc[7:4] == 4'h0) ? opc[3:0] : opc[7:4];
         case (sel)
            4'h0:    op = OP_WAIT;
            4'h1:    op = OP_AND;
            4'h2:    op = OP_OR;
            4'h3:    op = OP_XOR;
            4'h4:    op = (opc[7:4] == 4'h0) ? OP_NOT : OP_UNDEF;
            4'h5:    op = OP_ADD;
            4'h6:    op = OP_ADDU;
            4'h7:    op = OP_ADDC;
            4'h9:    op = OP_SUB;
            4'hA:    op = OP_SUBC;
            4'hB:    op = OP_CMP;
            4'hE:    op = OP_MUL;
            4'hF:    op = OP_CMPU;
            default: op = OP_UNDEF;
         endcase
      end
      return op;
   endfunction

   // Any amount bit above the field saturates to WIDTH; amounts >= WIDTH flush or sign-fill.
   function automatic logic [WIDTH-1:0] shift_sat(input logic [WIDTH-1:0] val,
                                                  input logic [WIDTH-1:0] amt_src,
                                                  input logic             left,
                                                  input logic             arith);
      logic [SHW:0]             amt;
      logic signed [WIDTH-1:0]  sval;
      logic [WIDTH-1:0]         res;
      sval = val;
      if (|(amt_src >> SHW))
         amt = SH_MAX;
      else
         amt = {1'b0, amt_src[SHW-1:0]};
      if (amt >= SH_MAX)
         res = (arith && !left) ? {WIDTH{val[WIDTH-1]}} : '0;
      else if (left)
         res = val << amt;
      else if (arith)
         res = sval >>> amt;
      else
         res = val >> amt;
      return res;
   endfunction

   state_t                  state, state_n;
   op_t                     op_c;
   logic                    accept, mul_fin, err_r;
   logic [SHW-1:0]          cnt;
   logic signed [WIDTH-1:0] a_s, b_s;
   logic [WIDTH:0]          sum_c, diff_c, mstep;
   logic [WIDTH-1:0]        res_c, mul_lo, mul_hi;
   logic [4:0]              flg_c;
   logic                    err_c, cin_add, cin_sub;
   logic [WIDTH-1:0]        m_a, m_lo, m_hi;

   assign a_s = a;
   assign b_s = b;

   always_comb begin
      op_c    = decode(opcode);
      cin_add = flags[4] & (op_c == OP_ADDC);
      cin_sub = flags[4] & (op_c == OP_SUBC);
      sum_c   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_add};
      diff_c  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin_sub};
      res_c   = result;
      flg_c   = flags;
      err_c   = 1'b0;
      case (op_c)
         OP_AND:  res_c = a & b;
         OP_OR:   res_c = a | b;
         OP_XOR:  res_c = a ^ b;
         OP_NOT:  res_c = ~a;
         OP_ADDU: res_c = sum_c[WIDTH-1:0];
         OP_ADD, OP_ADDC: begin
            res_c = sum_c[WIDTH-1:0];
            flg_c = {sum_c[WIDTH], 1'b0,
                     (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]),
                     ~|sum_c[WIDTH-1:0], 1'b0};
         end
         OP_SUB, OP_SUBC: begin
            res_c = diff_c[WIDTH-1:0];
            flg_c = {diff_c[WIDTH], 1'b0,
                     (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]),
                     ~|diff_c[WIDTH-1:0], 1'b0};
         end
         OP_CMP:  flg_c = {1'b0, a_s < b_s, 1'b0, a_s == b_s, a_s > b_s};
         OP_CMPU: flg_c = {1'b0, a < b, 1'b0, a == b, a > b};
         OP_LSH, OP_ALSH: res_c = shift_sat(a, b, 1'b1, 1'b0);
         OP_RSH:  res_c = shift_sat(a, b, 1'b0, 1'b0);
         OP_ARSH: res_c = shift_sat(a, b, 1'b0, 1'b1);
         OP_UNDEF: begin
            res_c = '0;
            flg_c = 5'b11111;
            err_c = 1'b1;
         end
         default: ;
      endcase
   end

   // Shift-add step: conditionally add multiplicand to the high half, then shift product right.
   always_comb begin
      mstep  = {1'b0, m_hi} + ({1'b0, m_a} & {(WIDTH+1){m_lo[0]}});
      mul_lo = {mstep[0], m_lo[WIDTH-1:1]};
      mul_hi = mstep[WIDTH:1];
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      mul_fin = 1'b0;
      ready   = (state != S_MULT);
      done    = (state == S_DONE);
      err     = (state == S_DONE) & err_r;
      case (state)
         S_IDLE, S_DONE: begin
            state_n = S_IDLE;
            if (start) begin
               accept  = 1'b1;
               state_n = (op_c == OP_MUL) ? S_MULT : S_DONE;
            end
         end
         S_MULT: begin
            if (cnt == CNT_LAST) begin
               mul_fin = 1'b1;
               state_n = S_DONE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result <= '0;
         flags  <= '0;
         err_r  <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         cnt   <= '0;
         err_r <= err_c;
         if (op_c != OP_MUL) begin
            result <= res_c;
            flags  <= flg_c;
         end
      end else if (state == S_MULT) begin
         cnt <= cnt + 1'b1;
         if (mul_fin) begin
            result <= mul_lo;
            flags  <= {|mul_hi, 1'b0, 1'b0, ~|mul_lo, 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         m_a  <= a;
         m_lo <= b;
         m_hi <= '0;
      end else if (state == S_MULT) begin
         m_hi <= mul_hi;
         m_lo <= mul_lo;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=16): directed cases plus random ops checked against an
// arithmetic reference model of the opcode map and PSR behaviour.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst_n, start;
   logic [7:0]  opcode;
   logic [15:0] a, b, result;
   logic [4:0]  flags;
   logic        ready, done, err;

   int n_checks = 0;
   int n_err    = 0;

   logic [15:0] m_res;
   logic [4:0]  m_flags;
   logic        m_err;

   alu_seq #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .a(a), .b(b),
      .result(result), .flags(flags), .ready(ready), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: flags packed {C,L,F,Z,N}; m_flags is the PSR as of the accept.
   task automatic model(input logic [7:0] opc, input logic [15:0] av, input logic [15:0] bv,
                        output bit is_mul);
      int     ua, ub, sa, sb, r, sr, cin, amt;
      longint p;
      ua = av; ub = bv; sa = $signed(av); sb = $signed(bv);
      cin = 0;
      is_mul = 1'b0;
      m_err = 1'b0;
      amt = (ub > 15) ? 16 : ub;
      if (opc == 8'h00) begin
      end else if (opc inside {8'h01, [8'h10:8'h1F]}) m_res = av & bv;
      else if (opc inside {8'h02, [8'h20:8'h2F]}) m_res = av | bv;
      else if (opc inside {8'h03, [8'h30:8'h3F]}) m_res = av ^ bv;
      else if (opc == 8'h04) m_res = ~av;
      else if (opc inside {8'h06, [8'h60:8'h6F]}) m_res = 16'(ua + ub);
      else if (opc inside {8'h05, [8'h50:8'h5F], 8'h07, [8'h70:8'h7F]}) begin
         if (opc == 8'h07 || opc[7:4] == 4'h7) cin = m_flags[4];
         r  = ua + ub + cin;
         sr = sa + sb + cin;
         m_res   = 16'(r);
         m_flags = {r > 65535, 1'b0, (sr > 32767) || (sr < -32768), m_res == 16'd0, 1'b0};
      end else if (opc inside {8'h09, [8'h90:8'h9F], 8'h0A, [8'hA0:8'hAF]}) begin
         if (opc == 8'h0A || opc[7:4] == 4'hA) cin = m_flags[4];
         r = ua - ub - cin;
         m_res   = 16'(r);
         m_flags = {r < 0, 1'b0, (av[15] != bv[15]) && (m_res[15] != av[15]),
                    m_res == 16'd0, 1'b0};
      end else if (opc inside {8'h0B, [8'hB0:8'hBF]})
         m_flags = {1'b0, sa < sb, 1'b0, sa == sb, sa > sb};
      else if (opc inside {8'h0F, [8'hF0:8'hFF]})
         m_flags = {1'b0, ua < ub, 1'b0, ua == ub, ua > ub};
      else if (opc inside {8'h0E, [8'hE0:8'hEF]}) begin
         p = longint'(ua) * longint'(ub);
         m_res   = 16'(p);
         m_flags = {(p >> 16) != 0, 1'b0, 1'b0, m_res == 16'd0, 1'b0};
         is_mul  = 1'b1;
      end else if (opc inside {8'h80, 8'h84, 8'h82, 8'h86})
         m_res = (amt >= 16) ? 16'h0000 : 16'(ua << amt);
      else if (opc inside {8'h81, 8'h85})
         m_res = (amt >= 16) ? 16'h0000 : 16'(ua >> amt);
      else if (opc inside {8'h83, 8'h87})
         m_res = 16'(sa >>> ((amt > 15) ? 15 : amt));
      else begin
         m_res   = 16'h0000;
         m_flags = 5'b11111;
         m_err   = 1'b1;
      end
   endtask

   // Present one op, wait (bounded) for done, compare everything against the model.
   task automatic issue(input logic [7:0] opc, input logic [15:0] av, input logic [15:0] bv);
      bit is_mul;
      int lat;
      model(opc, av, bv, is_mul);
      start = 1'b1; opcode = opc; a = av; b = bv;
      @(posedge clk); #1;
      start = 1'b0; a = 16'($urandom); b = 16'($urandom);
      lat = 1;
      while (done !== 1'b1 && lat < 40) begin
         check("busy_ready", ready, 1'b0);
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, is_mul ? 17 : 1);
      check("done", done, 1'b1);
      check("err", err, m_err);
      check("result", result, m_res);
      check("flags", flags, m_flags);
      check("ready_done", ready, 1'b1);
   endtask

   initial begin
      int ndone;
      logic [7:0]  ropc;
      logic [15:0] ra, rb;
      logic [15:0] edge_vals [5];
      edge_vals = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001};

      rst_n = 1'b0; start = 1'b0; opcode = 8'h00; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_result", result, 16'h0000);
      check("rst_flags", flags, 5'b00000);
      check("rst_ready", ready, 1'b1);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      m_res = '0; m_flags = '0; m_err = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      issue(8'h05, 16'h7FFF, 16'h0001);
      check("add_ovf_res", result, 16'h8000);
      check("add_ovf_flags", flags, 5'b00100);

      issue(8'h05, 16'hFFFF, 16'h0001);
      check("add_wrap_res", result, 16'h0000);
      check("add_wrap_flags", flags, 5'b10010);
      issue(8'h07, 16'h0001, 16'h0001);
      check("addc_res", result, 16'h0003);
      check("addc_c", flags[4], 1'b0);

      issue(8'h0B, 16'hFFFF, 16'h0001);
      check("cmp_res", result, 16'h0003);
      check("cmp_l", flags[3], 1'b1);
      check("cmp_n", flags[0], 1'b0);
      issue(8'h0F, 16'hFFFF, 16'h0001);
      check("cmpu_n", flags[0], 1'b1);
      check("cmpu_l", flags[3], 1'b0);

      issue(8'h87, 16'h8000, 16'h0004);
      check("arsh_res", result, 16'hF800);
      check("arsh_flags", flags, 5'b00001);
      issue(8'h84, 16'h0001, 16'h0010);
      check("lsh_sat_res", result, 16'h0000);

      @(posedge clk); #1;
      check("idle_done", done, 1'b0);

      issue(8'hE3, 16'h0123, 16'h0010);
      check("muli_res", result, 16'h1230);
      check("muli_c", flags[4], 1'b0);

      // Abort a multiply with reset; a stray start mid-multiply must be ignored.
      start = 1'b1; opcode = 8'hE3; a = 16'h0123; b = 16'h0010;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         check("abort_busy", ready, 1'b0);
         if (k == 5) begin start = 1'b1; opcode = 8'h05; end
         if (k == 6) start = 1'b0;
         if (k == 8) rst_n = 1'b0;
         @(posedge clk); #1;
      end
      check("abort_ready", ready, 1'b1);
      check("abort_result", result, 16'h0000);
      check("abort_flags", flags, 5'b00000);
      check("abort_done", done, 1'b0);
      rst_n = 1'b1;
      m_res = '0; m_flags = '0;
      ndone = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (done === 1'b1) ndone++;
      end
      check("abort_no_done", ndone, 0);

      issue(8'h08, 16'h1234, 16'h5678);
      check("undef_res", result, 16'h0000);
      check("undef_flags", flags, 5'b11111);
      check("undef_err", err, 1'b1);

      for (int k = 0; k < 150; k++) begin
         ropc = 8'($urandom_range(0, 255));
         ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : 16'($urandom);
         rb = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
         issue(ropc, ra, rb);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
            check("rand_idle_done", done, 1'b0);
            check("rand_idle_err", err, 1'b0);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
